// File: rtl/unidade_busca.sv
// Fetch stage for the nRisc datapath: program counter, instruction register and
// valid/ready delivery to the decoder, with stall, redirect and halt handling.
module unidade_busca #(
  parameter logic [7:0] RESET_PC  = 8'd0,
  parameter logic [7:0] HALT_WORD = 8'hFF,
  parameter int         COUNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic [7:0]         endereco,
  input  logic [7:0]         instrucao,
  output logic [7:0]         instr_out,
  output logic [7:0]         instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [7:0]         redirect_target,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    START  = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [7:0]         pc, pc_next;
  logic [7:0]         instr_out_next, instr_pc_next;
  logic               valid_next, halted_next;
  logic [COUNT_W-1:0] count_next;
  logic               transfer, slot_free;

  assign transfer  = instr_valid & instr_ready;
  assign slot_free = !instr_valid | instr_ready;
  assign endereco  = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= START;
      pc          <= RESET_PC;
      instr_out   <= 8'd0;
      instr_pc    <= 8'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_out   <= instr_out_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= valid_next;
      halted      <= halted_next;
      fetch_count <= count_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    instr_out_next = instr_out;
    instr_pc_next  = instr_pc;
    valid_next     = instr_valid;
    halted_next    = halted;
    count_next     = fetch_count;

    if (transfer && (fetch_count != {COUNT_W{1'b1}}))
      count_next = fetch_count + COUNT_W'(1);

    case (state)
      START: state_next = FETCH;
      FETCH: begin
        if (slot_free) begin
          instr_out_next = instrucao;
          instr_pc_next  = pc;
          valid_next     = 1'b1;
          if (instrucao == HALT_WORD) begin
            state_next  = HALTED;
            halted_next = 1'b1;
          end else begin
            pc_next = pc + 8'd1;
          end
        end
      end
      HALTED: begin
        // Only the already-captured halt word can still leave the stage.
        if (transfer)
          valid_next = 1'b0;
      end
      default: state_next = START;
    endcase

    // Redirect overrides everything, including a same-edge transfer.
    if (redirect_valid) begin
      pc_next     = redirect_target;
      valid_next  = 1'b0;
      halted_next = 1'b0;
      state_next  = FETCH;
      count_next  = fetch_count;
    end
  end

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed scenarios plus randomized ready/redirect traffic
// checked against a stream-level model of which (pc, word) pairs the decoder accepts.
module tb_unidade_busca;
  localparam int         COUNT_W = 5;
  localparam int         CMAX    = (1 << COUNT_W) - 1;
  localparam logic [7:0] HALT    = 8'hFF;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [7:0]         endereco;
  logic [7:0]         instrucao;
  logic [7:0]         instr_out;
  logic [7:0]         instr_pc;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [7:0]         redirect_target = 8'd0;
  logic               halted;
  logic [COUNT_W-1:0] fetch_count;

  logic [7:0] mem [256];
  assign instrucao = mem[endereco];

  int n_checks = 0;
  int n_fail   = 0;

  // model: next address the decoder should see, accepted count, halt delivered
  logic [7:0] m_pc;
  int         m_cnt;
  bit         m_halt;

  unidade_busca #(.RESET_PC(8'd0), .HALT_WORD(HALT), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset), .endereco(endereco), .instrucao(instrucao),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    m_pc   = 8'd0;
    m_cnt  = 0;
    m_halt = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_endereco"}, 32'(endereco), 32'h0);
    check({tag, "_instr_out"}, 32'(instr_out), 32'h0);
    check({tag, "_instr_pc"}, 32'(instr_pc), 32'h0);
    check({tag, "_valid"}, 32'(instr_valid), 32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
    check({tag, "_count"}, 32'(fetch_count), 32'h0);
  endtask

  // One clock: score any accepted word against the model, then check state after the edge.
  task automatic tick();
    if (instr_valid && instr_ready && !redirect_valid) begin
      check("stream_pc", 32'(instr_pc), 32'(m_pc));
      check("stream_word", 32'(instr_out), 32'(mem[m_pc]));
      if (mem[m_pc] == HALT) m_halt = 1'b1;
      else m_pc = m_pc + 8'd1;
      if (m_cnt < CMAX) m_cnt++;
    end
    if (redirect_valid) begin
      m_pc   = redirect_target;
      m_halt = 1'b0;
    end
    @(posedge clock);
    #1;
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    if (m_halt) begin
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_valid", 32'(instr_valid), 32'h0);
      check("halt_pc", 32'(endereco), 32'(m_pc));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_values("rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, 7'(i)};
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[11] = 8'hBB; mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hA2;
  endtask

  logic [7:0] prog [4];
  logic [7:0] wrap_pc [4];
  int c_saved;

  initial begin
    prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44;
    wrap_pc[0] = 8'hFE; wrap_pc[1] = 8'hFF; wrap_pc[2] = 8'h00; wrap_pc[3] = 8'h01;
    load_program();
    model_init();
    #3;

    // straight-line stream with ready held high
    instr_ready = 1'b1;
    do_reset();
    tick();
    check("t1_bubble", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_word", 32'(instr_out), 32'(prog[i]));
      check("t1_pc", 32'(instr_pc), 32'(i));
      check("t1_valid", 32'(instr_valid), 32'h1);
    end
    tick();
    check("t1_count4", 32'(fetch_count), 32'd4);

    // stall for three cycles after the first capture
    instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_hold_word", 32'(instr_out), 32'h11);
      check("t2_hold_pc", 32'(endereco), 32'h1);
      check("t2_hold_valid", 32'(instr_valid), 32'h1);
    end
    instr_ready = 1'b1;
    tick();
    check("t2_resume", 32'(instr_out), 32'h22);
    tick();
    tick();

    // halt word at address 2, then restart by redirect
    mem[2] = HALT;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("t3_halted", 32'(halted), 32'h1);
    check("t3_pc", 32'(endereco), 32'h2);
    check("t3_valid", 32'(instr_valid), 32'h0);
    check("t3_count", 32'(fetch_count), 32'd3);
    tick();
    tick();
    check("t3_still_idle", 32'(instr_valid), 32'h0);
    mem[2] = 8'h33;
    redirect_valid = 1'b1;
    redirect_target = 8'h00;
    tick();
    redirect_valid = 1'b0;
    check("t3_unhalt", 32'(halted), 32'h0);
    check("t3_flush", 32'(instr_valid), 32'h0);
    check("t3_newpc", 32'(endereco), 32'h0);
    tick();
    check("t3_restart", 32'(instr_out), 32'h11);
    tick();
    tick();

    // redirect colliding with a transfer
    check("t4_pre_valid", 32'(instr_valid), 32'h1);
    c_saved = m_cnt;
    redirect_valid = 1'b1;
    redirect_target = 8'h0B;
    tick();
    redirect_valid = 1'b0;
    check("t4_not_counted", 32'(fetch_count), 32'(c_saved));
    check("t4_flush", 32'(instr_valid), 32'h0);
    tick();
    check("t4_word", 32'(instr_out), 32'hBB);
    check("t4_pc", 32'(instr_pc), 32'h0B);

    // pc wrap from FF to 00
    redirect_valid = 1'b1;
    redirect_target = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_wrap_pc", 32'(instr_pc), 32'(wrap_pc[i]));
    end

    // asynchronous reset while stalled
    instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    check("t6_pre_valid", 32'(instr_valid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("t6_async");
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_init();
    instr_ready = 1'b1;
    tick();
    check("t6_bubble", 32'(instr_valid), 32'h0);
    tick();
    check("t6_pc", 32'(instr_pc), 32'h0);
    check("t6_word", 32'(instr_out), 32'h11);

    // randomized traffic against the stream model
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : 8'($urandom);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      instr_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid  = ($urandom_range(0, 39) == 0);
      redirect_target = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
